// File: rtl/dcache_ctrl_if.sv
// CPU-side and memory-side buses of the L1 data cache.
// Master drives the request, slave answers it.
interface dcache_cpu_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] cpu_addr_i;
  logic [DATA_W-1:0] cpu_data_i;
  logic              cpu_MemRead_i;
  logic              cpu_MemWrite_i;
  logic [DATA_W-1:0] cpu_data_o;
  logic              cpu_stall_o;

  modport master (
    output cpu_addr_i, cpu_data_i,
    output cpu_MemRead_i, cpu_MemWrite_i,
    input  cpu_data_o, cpu_stall_o
  );
  modport slave (
    input  cpu_addr_i, cpu_data_i,
    input  cpu_MemRead_i, cpu_MemWrite_i,
    output cpu_data_o, cpu_stall_o
  );
endinterface

interface dcache_mem_if #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256
);
  logic              mem_enable_o;
  logic              mem_write_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [LINE_W-1:0] mem_data_o;
  logic [LINE_W-1:0] mem_data_i;
  logic              mem_ack_i;

  modport master (
    output mem_enable_o, mem_write_o,
    output mem_addr_o, mem_data_o,
    input  mem_data_i, mem_ack_i
  );
  modport slave (
    input  mem_enable_o, mem_write_o,
    input  mem_addr_o, mem_data_o,
    output mem_data_i, mem_ack_i
  );
endinterface

// File: rtl/dcache_ctrl.sv
// Direct-mapped write-back write-allocate L1 data cache.
// Hits are zero-stall; misses stall while the line is evicted/refilled.
module dcache_ctrl #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int INDEX_W = 5,
  parameter int LINE_W  = 256
) (
  input  logic         clk_i,
  input  logic         rst_i,
  dcache_cpu_if.slave  cpu,
  dcache_mem_if.master mem
);
  localparam int OFFSET_W = $clog2(LINE_W / 8);
  localparam int TAG_W    = ADDR_W - INDEX_W - OFFSET_W;
  localparam int WORDS    = LINE_W / DATA_W;
  localparam int WSEL_W   = $clog2(WORDS);
  localparam int NLINES   = 1 << INDEX_W;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WB,
    S_ALLOC,
    S_DONE
  } state_t;

  state_t r_state;
  logic [NLINES-1:0] r_valid;
  logic [NLINES-1:0] r_dirty;
  logic [TAG_W-1:0]  r_tag  [NLINES];
  logic [LINE_W-1:0] r_data [NLINES];

  logic              r_mem_en;
  logic              r_mem_wr;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [LINE_W-1:0] r_mem_data;

  logic [TAG_W-1:0]   w_tag;
  logic [INDEX_W-1:0] w_idx;
  logic [WSEL_W-1:0]  w_word;
  logic [LINE_W-1:0]  w_line;
  logic               w_req;
  logic               w_hit;
  logic               w_idle;
  logic               w_st_hit;
  logic               w_ld_hit;
  logic               w_fill;
  logic               w_unused;

  assign w_tag    = cpu.cpu_addr_i[ADDR_W-1 -: TAG_W];
  assign w_idx    = cpu.cpu_addr_i[OFFSET_W +: INDEX_W];
  assign w_word   = cpu.cpu_addr_i[OFFSET_W-1 -: WSEL_W];
  assign w_unused = ^cpu.cpu_addr_i[OFFSET_W-WSEL_W-1:0];

  assign w_line   = r_data[w_idx];
  assign w_req    = cpu.cpu_MemRead_i | cpu.cpu_MemWrite_i;
  assign w_hit    = r_valid[w_idx] & (r_tag[w_idx] == w_tag);
  assign w_idle   = (r_state == S_IDLE);
  assign w_st_hit = w_idle & cpu.cpu_MemWrite_i & w_hit;
  assign w_ld_hit = w_idle & cpu.cpu_MemRead_i
                  & ~cpu.cpu_MemWrite_i & w_hit;
  assign w_fill   = (r_state == S_ALLOC) & mem.mem_ack_i;

  // Stall/data are gated by reset so a held request reads as idle.
  assign cpu.cpu_stall_o = rst_i
    & (~w_idle | (w_req & ~w_hit));
  assign cpu.cpu_data_o = (rst_i & w_ld_hit)
    ? w_line[w_word*DATA_W +: DATA_W] : '0;

  assign mem.mem_enable_o = r_mem_en;
  assign mem.mem_write_o  = r_mem_wr;
  assign mem.mem_addr_o   = r_mem_addr;
  assign mem.mem_data_o   = r_mem_data;

  always_ff @(posedge clk_i) begin
    if (w_fill) begin
      r_data[w_idx] <= mem.mem_data_i;
      r_tag[w_idx]  <= w_tag;
    end else if (w_st_hit) begin
      r_data[w_idx][w_word*DATA_W +: DATA_W] <= cpu.cpu_data_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state    <= S_IDLE;
      r_valid    <= '0;
      r_dirty    <= '0;
      r_mem_en   <= 1'b0;
      r_mem_wr   <= 1'b0;
      r_mem_addr <= '0;
      r_mem_data <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_st_hit) begin
            r_dirty[w_idx] <= 1'b1;
          end else if (w_req && !w_hit) begin
            r_mem_en <= 1'b1;
            if (r_valid[w_idx] && r_dirty[w_idx]) begin
              r_state    <= S_WB;
              r_mem_wr   <= 1'b1;
              r_mem_addr <= {r_tag[w_idx], w_idx,
                             {OFFSET_W{1'b0}}};
              r_mem_data <= w_line;
            end else begin
              r_state    <= S_ALLOC;
              r_mem_wr   <= 1'b0;
              r_mem_addr <= {w_tag, w_idx,
                             {OFFSET_W{1'b0}}};
            end
          end
        end
        S_WB: begin
          if (mem.mem_ack_i) begin
            r_state    <= S_ALLOC;
            r_mem_wr   <= 1'b0;
            r_mem_addr <= {w_tag, w_idx,
                           {OFFSET_W{1'b0}}};
          end
        end
        S_ALLOC: begin
          if (mem.mem_ack_i) begin
            r_state        <= S_DONE;
            r_mem_en       <= 1'b0;
            r_valid[w_idx] <= 1'b1;
            r_dirty[w_idx] <= 1'b0;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed bench for dcache_ctrl: fills, hits, write-back,
// clean conflict, long ack delay and reset mid-refill.
module tb_dcache_ctrl;
  logic clk_i = 1'b0;
  logic rst_i = 1'b0;

  dcache_cpu_if #(.ADDR_W(32), .DATA_W(32)) cpu_bus ();
  dcache_mem_if #(.ADDR_W(32), .LINE_W(256)) mem_bus ();

  dcache_ctrl dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .cpu   (cpu_bus.slave),
    .mem   (mem_bus.master)
  );

  always #5 clk_i = ~clk_i;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag,
                     input logic [255:0] got,
                     input logic [255:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  function automatic logic [255:0] mk_line(
      input logic [31:0] base);
    logic [255:0] l;
    for (int i = 0; i < 8; i++)
      l[i*32 +: 32] = base + 32'(i);
    return l;
  endfunction

  task automatic req(input logic [31:0] a,
                     input logic rd, input logic wr,
                     input logic [31:0] d);
    cpu_bus.cpu_addr_i     = a;
    cpu_bus.cpu_MemRead_i  = rd;
    cpu_bus.cpu_MemWrite_i = wr;
    cpu_bus.cpu_data_i     = d;
    #1;
  endtask

  logic [255:0] line;
  logic [255:0] wb_line;

  initial begin
    cpu_bus.cpu_addr_i     = '0;
    cpu_bus.cpu_data_i     = '0;
    cpu_bus.cpu_MemRead_i  = 1'b0;
    cpu_bus.cpu_MemWrite_i = 1'b0;
    mem_bus.mem_data_i     = '0;
    mem_bus.mem_ack_i      = 1'b0;

    #12;
    chk("rst_stall", cpu_bus.cpu_stall_o, 0);
    chk("rst_en", mem_bus.mem_enable_o, 0);
    chk("rst_addr", mem_bus.mem_addr_o, 0);
    rst_i = 1'b1;
    step();

    // 1: cold load miss on 0x40
    req(32'h40, 1, 0, 0);
    chk("t1_miss_stall", cpu_bus.cpu_stall_o, 1);
    chk("t1_miss_data", cpu_bus.cpu_data_o, 0);
    step();
    chk("t1_alloc_en", mem_bus.mem_enable_o, 1);
    chk("t1_alloc_wr", mem_bus.mem_write_o, 0);
    chk("t1_alloc_addr", mem_bus.mem_addr_o, 32'h40);
    chk("t1_alloc_stall", cpu_bus.cpu_stall_o, 1);
    line = mk_line(32'hA000_0000);
    line[2*32 +: 32] = 32'hDEAD_BEEF;
    mem_bus.mem_data_i = line;
    mem_bus.mem_ack_i  = 1'b1;
    step();
    mem_bus.mem_ack_i = 1'b0;
    chk("t1_done_en", mem_bus.mem_enable_o, 0);
    chk("t1_done_stall", cpu_bus.cpu_stall_o, 1);
    step();
    chk("t1_hit_stall", cpu_bus.cpu_stall_o, 0);
    chk("t1_hit_w0", cpu_bus.cpu_data_o, 32'hA000_0000);
    req(32'h48, 1, 0, 0);
    chk("t1_hit_w2", cpu_bus.cpu_data_o, 32'hDEAD_BEEF);
    chk("t1_hit_stall2", cpu_bus.cpu_stall_o, 0);

    // 2: store hit then load back
    req(32'h44, 0, 1, 32'h1234_5678);
    chk("t2_st_stall", cpu_bus.cpu_stall_o, 0);
    chk("t2_st_data", cpu_bus.cpu_data_o, 0);
    step();
    req(32'h44, 1, 0, 0);
    chk("t2_ld", cpu_bus.cpu_data_o, 32'h1234_5678);
    chk("t2_ld_stall", cpu_bus.cpu_stall_o, 0);
    chk("t2_dirty", dut.r_dirty[2], 1);
    req(32'h46, 1, 0, 0);
    chk("t2_ld_lowbits", cpu_bus.cpu_data_o, 32'h1234_5678);

    // 3+5: dirty conflict, ack held off 20 cycles
    req(32'h444, 1, 0, 0);
    chk("t3_miss_stall", cpu_bus.cpu_stall_o, 1);
    step();
    wb_line = line;
    wb_line[1*32 +: 32] = 32'h1234_5678;
    for (int c = 0; c < 20; c++) begin
      chk("t5_wb_en", mem_bus.mem_enable_o, 1);
      chk("t5_wb_wr", mem_bus.mem_write_o, 1);
      chk("t5_wb_addr", mem_bus.mem_addr_o, 32'h40);
      chk("t5_wb_data", mem_bus.mem_data_o, wb_line);
      chk("t5_wb_stall", cpu_bus.cpu_stall_o, 1);
      step();
    end
    line = mk_line(32'hB000_0000);
    mem_bus.mem_data_i = line;
    mem_bus.mem_ack_i  = 1'b1;
    step();
    mem_bus.mem_ack_i = 1'b0;
    chk("t3_alloc_en", mem_bus.mem_enable_o, 1);
    chk("t3_alloc_wr", mem_bus.mem_write_o, 0);
    chk("t3_alloc_addr", mem_bus.mem_addr_o, 32'h440);
    chk("t3_alloc_stall", cpu_bus.cpu_stall_o, 1);
    step();
    chk("t3_wait_en", mem_bus.mem_enable_o, 1);
    mem_bus.mem_ack_i = 1'b1;
    step();
    mem_bus.mem_ack_i = 1'b0;
    chk("t3_done_en", mem_bus.mem_enable_o, 0);
    chk("t3_done_stall", cpu_bus.cpu_stall_o, 1);
    step();
    chk("t3_hit_stall", cpu_bus.cpu_stall_o, 0);
    chk("t3_hit_data", cpu_bus.cpu_data_o, 32'hB000_0001);

    // 4: clean conflict goes straight to ALLOCATE
    req(32'h84C, 1, 0, 0);
    chk("t4_miss_stall", cpu_bus.cpu_stall_o, 1);
    step();
    chk("t4_alloc_en", mem_bus.mem_enable_o, 1);
    chk("t4_alloc_wr", mem_bus.mem_write_o, 0);
    chk("t4_alloc_addr", mem_bus.mem_addr_o, 32'h840);
    step();
    chk("t4_wait_wr", mem_bus.mem_write_o, 0);
    line = mk_line(32'hC000_0000);
    mem_bus.mem_data_i = line;
    mem_bus.mem_ack_i  = 1'b1;
    step();
    mem_bus.mem_ack_i = 1'b0;
    chk("t4_done_wr", mem_bus.mem_write_o, 0);
    step();
    chk("t4_hit_stall", cpu_bus.cpu_stall_o, 0);
    chk("t4_hit_data", cpu_bus.cpu_data_o, 32'hC000_0003);

    // 6: reset in the middle of a refill
    req(32'h1000, 1, 0, 0);
    step();
    chk("t6_alloc_en", mem_bus.mem_enable_o, 1);
    chk("t6_alloc_addr", mem_bus.mem_addr_o, 32'h1000);
    rst_i = 1'b0;
    #1;
    chk("t6_rst_en", mem_bus.mem_enable_o, 0);
    chk("t6_rst_wr", mem_bus.mem_write_o, 0);
    chk("t6_rst_addr", mem_bus.mem_addr_o, 0);
    chk("t6_rst_mdata", mem_bus.mem_data_o, 0);
    chk("t6_rst_stall", cpu_bus.cpu_stall_o, 0);
    chk("t6_rst_data", cpu_bus.cpu_data_o, 0);
    #1;
    rst_i = 1'b1;
    req(32'h0, 0, 0, 0);
    mem_bus.mem_ack_i = 1'b1;
    step();
    mem_bus.mem_ack_i = 1'b0;
    chk("t6_stray_en", mem_bus.mem_enable_o, 0);
    chk("t6_stray_stall", cpu_bus.cpu_stall_o, 0);
    chk("t6_stray_valid0", dut.r_valid[0], 0);
    req(32'h84C, 1, 0, 0);
    chk("t6_old_miss", cpu_bus.cpu_stall_o, 1);
    chk("t6_old_data", cpu_bus.cpu_data_o, 0);
    step();
    chk("t6_realloc_en", mem_bus.mem_enable_o, 1);
    chk("t6_realloc_addr", mem_bus.mem_addr_o, 32'h840);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
